// File: rtl/inst_fetch_queue_pkg.sv
// Shared widths, reset constants and entry layout for the IF -> decoder instruction queue.
package inst_fetch_queue_pkg;

  localparam int unsigned ID_WIDTH        = 32;
  localparam int unsigned ADDRESS_WIDTH   = 32;
  localparam logic [ID_WIDTH-1:0] NOP     = 32'h0000_0013;
  localparam int unsigned INSTQ_DEPTH_DEF = 8;
  localparam int unsigned INSTQ_SLACK_DEF = 2;

  typedef struct packed {
    logic [ID_WIDTH-1:0]      inst;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic                     pred;
  } instq_entry_t;

endpackage

// File: rtl/inst_fetch_queue_ram.sv
// Queue storage: DEPTH entries, one synchronous write port, one asynchronous read port; never reset.
module instq_ram
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = INSTQ_DEPTH_DEF,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  instq_entry_t     wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output instq_entry_t     rd_data
);

  instq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Parametrised instruction queue between IF and decoder with count-based full/empty and sticky overflow.
// Optional build macro INSTQ_BYPASS_EN: empty-queue push goes straight to the decoder registers.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH      = INSTQ_DEPTH_DEF,
  parameter int unsigned SLACK      = INSTQ_SLACK_DEF,
  parameter int unsigned FLUSH_SRCS = 3
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       stall_in,
  input  logic [FLUSH_SRCS-1:0]      flush_in,
  input  logic                       if_en_in,
  input  logic [ID_WIDTH-1:0]        if_inst_in,
  input  logic [ADDRESS_WIDTH-1:0]   if_pc_in,
  input  logic                       if_pred_in,
  output logic                       if_rdy_out,
  output logic                       dec_en_out,
  output logic [ID_WIDTH-1:0]        dec_inst_out,
  output logic [ADDRESS_WIDTH-1:0]   dec_pc_out,
  output logic                       dec_pred_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out,
  output logic                       ovf_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_SLACK = CNT_W'(SLACK);

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic             flush, full, empty, bypass, push, pop, wr_en;
  instq_entry_t     wr_data, rd_data;

  assign flush = |flush_in;
  assign full  = (count == CNT_DEPTH);
  assign empty = (count == '0);

`ifdef INSTQ_BYPASS_EN
  assign bypass = empty && if_en_in && !stall_in;
`else
  assign bypass = 1'b0;
`endif

  // A full queue rejects the push even when a pop frees a slot on the same edge.
  assign push  = if_en_in && !full && !bypass;
  assign pop   = !stall_in && !empty;
  assign wr_en = rdy_in && !flush && push;

  assign wr_data    = '{inst: if_inst_in, pc: if_pc_in, pred: if_pred_in};
  assign if_rdy_out = (CNT_DEPTH - count) >= CNT_SLACK;
  assign count_out  = count;

  instq_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk     (clk_in),
    .wr_en   (wr_en),
    .wr_addr (tail),
    .wr_data (wr_data),
    .rd_addr (head),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      dec_en_out   <= 1'b0;
      dec_inst_out <= NOP;
      dec_pc_out   <= '0;
      dec_pred_out <= 1'b0;
      ovf_out      <= 1'b0;
    end else if (rdy_in) begin
      if (flush) begin
        head       <= '0;
        tail       <= '0;
        count      <= '0;
        dec_en_out <= 1'b0;
      end else begin
        if (push) tail <= tail + PTR_ONE;
        if (if_en_in && full) ovf_out <= 1'b1;

        if (pop) begin
          head         <= head + PTR_ONE;
          dec_en_out   <= 1'b1;
          dec_inst_out <= rd_data.inst;
          dec_pc_out   <= rd_data.pc;
          dec_pred_out <= rd_data.pred;
        end else if (bypass) begin
          dec_en_out   <= 1'b1;
          dec_inst_out <= if_inst_in;
          dec_pc_out   <= if_pc_in;
          dec_pred_out <= if_pred_in;
        end else begin
          dec_en_out <= 1'b0;
        end

        if (push && !pop)      count <= count + CNT_ONE;
        else if (pop && !push) count <= count - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue (default build, DEPTH=8, SLACK=2, 3 flush sources).
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        stall_in;
  logic [2:0]  flush_in;
  logic        if_en_in;
  logic [31:0] if_inst_in;
  logic [31:0] if_pc_in;
  logic        if_pred_in;
  logic        if_rdy_out;
  logic        dec_en_out;
  logic [31:0] dec_inst_out;
  logic [31:0] dec_pc_out;
  logic        dec_pred_out;
  logic [3:0]  count_out;
  logic        ovf_out;

  int unsigned n_asserts = 0;
  int unsigned n_fail    = 0;

  inst_fetch_queue #(
    .DEPTH      (8),
    .SLACK      (2),
    .FLUSH_SRCS (3)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .stall_in     (stall_in),
    .flush_in     (flush_in),
    .if_en_in     (if_en_in),
    .if_inst_in   (if_inst_in),
    .if_pc_in     (if_pc_in),
    .if_pred_in   (if_pred_in),
    .if_rdy_out   (if_rdy_out),
    .dec_en_out   (dec_en_out),
    .dec_inst_out (dec_inst_out),
    .dec_pc_out   (dec_pc_out),
    .dec_pred_out (dec_pred_out),
    .count_out    (count_out),
    .ovf_out      (ovf_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic en, input logic [31:0] inst, input logic [31:0] pc, input logic pred);
    if_en_in   = en;
    if_inst_in = inst;
    if_pc_in   = pc;
    if_pred_in = pred;
  endtask

  initial begin
    rst_in   = 1'b1;
    rdy_in   = 1'b1;
    stall_in = 1'b0;
    flush_in = '0;
    drive(1'b0, '0, '0, 1'b0);
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;

    check("rst_count", count_out, 0);
    check("rst_dec_en", dec_en_out, 0);
    check("rst_dec_inst", dec_inst_out, 32'h13);
    check("rst_dec_pc", dec_pc_out, 0);
    check("rst_ovf", ovf_out, 0);
    check("rst_if_rdy", if_rdy_out, 1);

    // Latency through storage: visible after the second edge.
    drive(1'b1, 32'h0000_0013, 32'h100, 1'b1);
    step();
    check("lat_e1_count", count_out, 1);
    check("lat_e1_dec_en", dec_en_out, 0);
    drive(1'b0, '0, '0, 1'b0);
    step();
    check("lat_e2_dec_en", dec_en_out, 1);
    check("lat_e2_pc", dec_pc_out, 32'h100);
    check("lat_e2_inst", dec_inst_out, 32'h13);
    check("lat_e2_pred", dec_pred_out, 1);
    check("lat_e2_count", count_out, 0);
    step();
    check("lat_e3_dec_en", dec_en_out, 0);
    check("lat_e3_pc_hold", dec_pc_out, 32'h100);

    // Streaming 20 entries: pointers wrap, occupancy stays at 1.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h1000 + i, 32'h200 + 4 * i, i[0]);
      step();
      check("stream_count", count_out, 1);
      if (i == 0) begin
        check("stream_first_en", dec_en_out, 0);
      end else begin
        check("stream_en", dec_en_out, 1);
        check("stream_pc", dec_pc_out, 32'h200 + 4 * (i - 1));
        check("stream_inst", dec_inst_out, 32'h1000 + (i - 1));
        check("stream_pred", dec_pred_out, (i - 1) % 2);
      end
    end
    drive(1'b0, '0, '0, 1'b0);
    step();
    check("stream_last_pc", dec_pc_out, 32'h200 + 4 * 19);
    check("stream_last_en", dec_en_out, 1);
    check("stream_drain_count", count_out, 0);

    // Global enable low: nothing changes, dec_en_out holds its value.
    rdy_in = 1'b0;
    drive(1'b1, 32'hAAAA, 32'h777, 1'b1);
    step();
    check("hold_dec_en", dec_en_out, 1);
    check("hold_count", count_out, 0);
    check("hold_pc", dec_pc_out, 32'h200 + 4 * 19);
    rdy_in = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    step();
    check("hold_release_en", dec_en_out, 0);
    check("hold_release_count", count_out, 0);

    // Fill with decoder stalled: slack threshold, full, overflow.
    stall_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h2000 + i, 32'h300 + 4 * i, 1'b0);
      step();
    end
    check("fill6_count", count_out, 6);
    check("fill6_if_rdy", if_rdy_out, 1);
    drive(1'b1, 32'h2006, 32'h318, 1'b0);
    step();
    check("fill7_count", count_out, 7);
    check("fill7_if_rdy", if_rdy_out, 0);
    drive(1'b1, 32'h2007, 32'h31c, 1'b0);
    step();
    check("fill8_count", count_out, 8);
    check("fill8_ovf", ovf_out, 0);
    drive(1'b1, 32'hBAD0, 32'h800, 1'b0);
    step();
    check("ovf_count", count_out, 8);
    check("ovf_set", ovf_out, 1);

    // Full queue, push+pop together: pop delivered, push dropped.
    stall_in = 1'b0;
    drive(1'b1, 32'hDEAD, 32'h900, 1'b1);
    step();
    check("fullpp_count", count_out, 7);
    check("fullpp_en", dec_en_out, 1);
    check("fullpp_pc", dec_pc_out, 32'h300);
    check("fullpp_inst", dec_inst_out, 32'h2000);
    check("fullpp_ovf", ovf_out, 1);
    drive(1'b0, '0, '0, 1'b0);
    for (int i = 1; i < 8; i++) begin
      step();
      check("drain_pc", dec_pc_out, 32'h300 + 4 * i);
      check("drain_count", count_out, 7 - i);
    end
    step();
    check("drain_idle_en", dec_en_out, 0);
    check("drain_idle_count", count_out, 0);

    // Flush with concurrent push and pop at count 5.
    stall_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h3000 + i, 32'h400 + 4 * i, 1'b0);
      step();
    end
    stall_in = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    step();
    check("preflush_count", count_out, 5);
    check("preflush_en", dec_en_out, 1);
    flush_in = 3'b010;
    drive(1'b1, 32'h4444, 32'h600, 1'b0);
    step();
    check("flush_count", count_out, 0);
    check("flush_en", dec_en_out, 0);
    check("flush_ovf", ovf_out, 1);
    flush_in = '0;
    drive(1'b0, '0, '0, 1'b0);
    step();
    check("postflush_count", count_out, 0);
    check("postflush_en", dec_en_out, 0);
    drive(1'b1, 32'h5555, 32'h700, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0);
    step();
    check("postflush_pc", dec_pc_out, 32'h700);
    check("postflush_inst", dec_inst_out, 32'h5555);

    // Asynchronous reset between edges with entries queued.
    stall_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h6000 + i, 32'hA00 + 4 * i, 1'b0);
      step();
    end
    stall_in = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    step();
    check("prerst_count", count_out, 3);
    check("prerst_en", dec_en_out, 1);
    #2 rst_in = 1'b1;
    #1;
    check("arst_count", count_out, 0);
    check("arst_dec_en", dec_en_out, 0);
    check("arst_dec_inst", dec_inst_out, 32'h13);
    check("arst_dec_pc", dec_pc_out, 0);
    check("arst_if_rdy", if_rdy_out, 1);
    check("arst_ovf", ovf_out, 0);
    #1 rst_in = 1'b0;
    step();
    check("postrst_count", count_out, 0);
    check("postrst_en", dec_en_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
